sram_port_controller: RTL and testbench

Off-chip SRAM responder for the 16-bit MIPS on the DE2 board. It accepts single-word read/write requests from the memory stage or cache, and drives the external 256K×16 SRAM pins through a fixed multi-cycle access. It returns read data with a one-cycle response strobe. The CPU-side stall logic and this block must agree on access length through `WAIT_CYCLES`.

---
 rtl/sram_port_controller.sv | 125 ++++++++++++
 tb/tb_sram_port_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sram_port_controller.sv
// rtl/sram_port_controller.sv - single-word responder driving a 256Kx16 asynchronous SRAM
module sram_port_controller #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  // Final ACCESS cycle index; WAIT_CYCLES is limited to 2..15 so it fits the 4-bit counter.
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [3:0]          cnt;
  logic                we_q;
  logic [1:0]          be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request latch, access counter and read-data capture on the last ACCESS edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            be_q    <= req_be;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST && !we_q) rdata_q <= sram_dq_in;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic: one handshake yields exactly one fixed-length access and one response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = ACCESS;
      ACCESS:  if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state, counter and latched request only; WE rises one cycle early for hold time.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        sram_ce_n = 1'b0;
        if (we_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = (cnt == LAST);
          sram_ub_n  = ~be_q[1];
          sram_lb_n  = ~be_q[0];
        end else begin
          sram_oe_n = 1'b0;
          sram_ub_n = 1'b0;
          sram_lb_n = 1'b0;
        end
      end
      DONE: resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign resp_rdata  = rdata_q;

endmodule

// File: tb/tb_sram_port_controller.sv
// tb/tb_sram_port_controller.sv - directed vector bench for sram_port_controller
module tb_sram_port_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: WAIT_CYCLES = 2
  logic        a_valid = 1'b0, a_we = 1'b0, a_ready, a_resp_valid, a_dq_oe;
  logic [1:0]  a_be = 2'b00;
  logic [17:0] a_addr = '0, a_sram_addr;
  logic [15:0] a_wdata = '0, a_dq_in = '0, a_rdata, a_dq_out;
  logic        a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;

  // DUT B: WAIT_CYCLES = 4
  logic        b_valid = 1'b0, b_we = 1'b0, b_ready, b_resp_valid, b_dq_oe;
  logic [1:0]  b_be = 2'b00;
  logic [17:0] b_addr = '0, b_sram_addr;
  logic [15:0] b_wdata = '0, b_dq_in = '0, b_rdata, b_dq_out;
  logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;

  sram_port_controller #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_be(a_be), .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_rdata), .sram_addr(a_sram_addr), .sram_dq_in(a_dq_in),
    .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n),
    .sram_we_n(a_we_n), .sram_ub_n(a_ub_n), .sram_lb_n(a_lb_n)
  );

  sram_port_controller #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_be(b_be), .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_rdata), .sram_addr(b_sram_addr), .sram_dq_in(b_dq_in),
    .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n),
    .sram_we_n(b_we_n), .sram_ub_n(b_ub_n), .sram_lb_n(b_lb_n)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic        we;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] dqin;
    logic [57:0] exp;
  } vec_t;

  // {ready, resp_valid, rdata, addr, {ce_n,oe_n,we_n,ub_n,lb_n}, dq_oe, dq_out}
  function automatic logic [57:0] pk(logic rdy, logic rv, logic [15:0] rd, logic [17:0] ad,
                                     logic [4:0] ctl, logic oe, logic [15:0] dq);
    return {rdy, rv, rd, ad, ctl, oe, dq};
  endfunction

  function automatic vec_t mk(logic r, logic v, logic w, logic [1:0] be, logic [17:0] ad,
                              logic [15:0] wd, logic [15:0] di, logic [57:0] e);
    vec_t t;
    t.rst = r; t.valid = v; t.we = w; t.be = be; t.addr = ad;
    t.wdata = wd; t.dqin = di; t.exp = e;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  vec_t vecs[14];
  int   hs_cyc[3];
  int   hs_n, resp_n, we_low, resp_cyc;

  initial begin
    vecs[0]  = mk(1, 1, 0, 2'b00, 18'h00012, 16'h0000, 16'h0000, pk(1, 0, 16'h0000, 18'h00000, 5'b11111, 0, 16'h0000));
    vecs[1]  = mk(1, 1, 0, 2'b00, 18'h00012, 16'h0000, 16'h0000, pk(1, 0, 16'h0000, 18'h00000, 5'b11111, 0, 16'h0000));
    vecs[2]  = mk(0, 1, 0, 2'b00, 18'h00012, 16'h0000, 16'h0000, pk(0, 0, 16'h0000, 18'h00012, 5'b00100, 0, 16'h0000));
    vecs[3]  = mk(0, 0, 0, 2'b00, 18'h00012, 16'h0000, 16'h1111, pk(0, 0, 16'h0000, 18'h00012, 5'b00100, 0, 16'h0000));
    vecs[4]  = mk(0, 0, 0, 2'b00, 18'h00012, 16'h0000, 16'hBEEF, pk(0, 1, 16'hBEEF, 18'h00012, 5'b11111, 0, 16'h0000));
    vecs[5]  = mk(0, 0, 0, 2'b00, 18'h00012, 16'h0000, 16'h0000, pk(1, 0, 16'hBEEF, 18'h00012, 5'b11111, 0, 16'h0000));
    vecs[6]  = mk(0, 1, 1, 2'b11, 18'h3FFFF, 16'h1234, 16'h5A5A, pk(0, 0, 16'hBEEF, 18'h3FFFF, 5'b01000, 1, 16'h1234));
    vecs[7]  = mk(0, 0, 0, 2'b00, 18'h00001, 16'hFFFF, 16'h5A5A, pk(0, 0, 16'hBEEF, 18'h3FFFF, 5'b01100, 1, 16'h1234));
    vecs[8]  = mk(0, 0, 0, 2'b00, 18'h00001, 16'hFFFF, 16'h5A5A, pk(0, 1, 16'hBEEF, 18'h3FFFF, 5'b11111, 0, 16'h1234));
    vecs[9]  = mk(0, 0, 0, 2'b00, 18'h00001, 16'hFFFF, 16'h5A5A, pk(1, 0, 16'hBEEF, 18'h3FFFF, 5'b11111, 0, 16'h1234));
    vecs[10] = mk(0, 1, 1, 2'b01, 18'h00100, 16'h00AB, 16'h0000, pk(0, 0, 16'hBEEF, 18'h00100, 5'b01010, 1, 16'h00AB));
    vecs[11] = mk(0, 1, 0, 2'b11, 18'h00555, 16'h7777, 16'h0000, pk(0, 0, 16'hBEEF, 18'h00100, 5'b01110, 1, 16'h00AB));
    vecs[12] = mk(0, 1, 0, 2'b11, 18'h00555, 16'h7777, 16'h0000, pk(0, 1, 16'hBEEF, 18'h00100, 5'b11111, 0, 16'h00AB));
    vecs[13] = mk(0, 0, 0, 2'b00, 18'h00555, 16'h7777, 16'h0000, pk(1, 0, 16'hBEEF, 18'h00100, 5'b11111, 0, 16'h00AB));

    // Cycle-by-cycle vectors on the W=2 instance.
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; a_valid = vecs[i].valid; a_we = vecs[i].we; a_be = vecs[i].be;
      a_addr = vecs[i].addr; a_wdata = vecs[i].wdata; a_dq_in = vecs[i].dqin;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          64'(pk(a_ready, a_resp_valid, a_rdata, a_sram_addr,
                 {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}, a_dq_oe, a_dq_out)),
          64'(vecs[i].exp));
    end

    // Back-to-back reads with req_valid held until three handshakes.
    hs_n = 0; resp_n = 0;
    a_valid = 1'b1; a_we = 1'b0; a_be = 2'b00; a_addr = 18'h00020; a_dq_in = 16'hC0DE;
    for (int c = 0; c < 16; c++) begin
      if (a_resp_valid) resp_n++;
      if (a_valid && a_ready && hs_n < 3) begin
        hs_cyc[hs_n] = c;
        hs_n++;
      end
      @(posedge clk); #1;
      if (hs_n == 3) a_valid = 1'b0;
    end
    chk("b2b_handshakes", 64'(hs_n), 64'd3);
    chk("b2b_resp_pulses", 64'(resp_n), 64'd3);
    chk("b2b_spacing_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
    chk("b2b_spacing_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd4);
    chk("b2b_rdata", 64'(a_rdata), 64'hC0DE);

    // Full upper-byte write on the W=4 instance: WE low 3 cycles, response in cycle 5.
    we_low = 0; resp_cyc = -1;
    b_valid = 1'b1; b_we = 1'b1; b_be = 2'b10; b_addr = 18'h2AAAA; b_wdata = 16'h9C9C;
    @(posedge clk); #1;
    b_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) chk("w4_bytelanes", 64'({b_ub_n, b_lb_n, b_dq_oe}), 64'({1'b0, 1'b1, 1'b1}));
      if (!b_we_n) we_low++;
      if (b_resp_valid) resp_cyc = c;
      @(posedge clk); #1;
    end
    chk("w4_we_low_cycles", 64'(we_low), 64'd3);
    chk("w4_resp_cycle", 64'(resp_cyc), 64'd5);

    // Reset asserted in the second ACCESS cycle of a W=4 write.
    b_valid = 1'b1; b_we = 1'b1; b_be = 2'b11; b_addr = 18'h00155; b_wdata = 16'h4242;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("abort_cycle1_we", 64'(b_we_n), 64'd0);
    @(posedge clk); #1;
    chk("abort_cycle2_dqoe", 64'(b_dq_oe), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctl", 64'({b_we_n, b_ce_n, b_dq_oe, b_ready}), 64'({1'b1, 1'b1, 1'b0, 1'b1}));
    chk("abort_addr", 64'(b_sram_addr), 64'd0);
    resp_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (b_resp_valid) resp_n++;
      @(posedge clk); #1;
    end
    chk("abort_no_resp", 64'(resp_n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
